prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 clk  input  1  system clock; all flops update on posedge clk.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 load_start  input  1  single-cycle pulse that starts a load session.
REQ-004 rx_data  input  8  serial-link byte.
REQ-005 rx_valid  input  1  rx_data is valid.
REQ-006 rx_ready  output  1  loader accepts a byte this cycle.
REQ-007 mem_addr  output  8  program RAM write address.
REQ-008 mem_wdata  output  16  program RAM write word.
REQ-009 mem_we  output  1  program RAM write strobe, one cycle per word.
REQ-010 cpu_rst  output  1  held high to keep the control unit and PC in reset.
REQ-011 done  output  1  load finished successfully; level signal.
REQ-012 err  output  1  load aborted; level signal.

Function
REQ-013 A byte SHALL transfer only on a cycle where rx_valid and rx_ready are both high.
REQ-014 States SHALL be IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CSUM_HI, CSUM_LO, DONE and ERR.
REQ-015 rx_ready SHALL be high only in LEN_HI, LEN_LO, DAT_HI, DAT_LO, CSUM_HI and CSUM_LO.
REQ-016 A load_start pulse in IDLE, DONE or ERR SHALL:
  - enter LEN_HI;
  - clear done, err, the address counter and the checksum accumulator;
  - raise cpu_rst on the next edge.
REQ-017 A load_start pulse in any other state SHALL be ignored.
REQ-018 Words SHALL be big-endian: the HI byte arrives first and the LO byte second.
REQ-019 Length word N SHALL be the number of program words; legal range 1..256.
REQ-020 On N=0 or N>256, LEN_LO SHALL go to ERR.
REQ-021 DAT_LO SHALL go to WRITE once the LO byte has transferred.
REQ-022 WRITE SHALL last exactly one cycle:
  - mem_we=1, with mem_addr equal to the counter and mem_wdata equal to the assembled word;
  - rx_ready=0.
REQ-023 After each write, the counter SHALL increment by one.
REQ-024 Write-count handling SHALL be:
  - when the write count equals N, go to CSUM_HI (macro defined) or DONE (macro undefined);
  - otherwise return to DAT_HI.
REQ-025 The counter SHALL be 9 bits wide internally, so N=256 completes without aliasing address 0.
REQ-026 mem_addr SHALL be the counter's low 8 bits.
REQ-027 mem_we SHALL be 0 in every state other than WRITE.
REQ-028 cpu_rst SHALL be 1 in every state except DONE.
REQ-029 done=1 only in DONE; err=1 only in ERR.
REQ-030 DONE and ERR SHALL hold until rst or load_start.
REQ-031 If rx_valid stays low, the FSM SHALL wait indefinitely with no timeout.
REQ-032 Load latency with no stalls SHALL be 2+3N cycles from LEN_HI entry to DONE, plus 2 with the checksum enabled.

Reset
REQ-033 rst SHALL have priority over load_start.
REQ-034 On rst, including mid-load, the block SHALL return to IDLE with rx_ready=0, mem_we=0, done=0, err=0, cpu_rst=1, mem_addr=0 and mem_wdata=0.
REQ-035 Partially written RAM contents after a mid-load reset SHALL be left as-is.

Configuration
REQ-036 With PROG_LOADER_CHECKSUM_EN defined:
  - the accumulator SHALL sum N and every data word, modulo 2^16;
  - a trailing checksum word SHALL be received in CSUM_HI and CSUM_LO;
  - a match SHALL go to DONE; a mismatch SHALL go to ERR.
REQ-037 With PROG_LOADER_CHECKSUM_EN undefined, the CSUM states and the accumulator SHALL not exist, and the last WRITE SHALL go directly to DONE.

Structure
REQ-038 The shared SAP package SHALL hold:
  - the state encoding constants;
  - RAM_ADDR_W=8 and WORD_W=16;
  - MAX_PROG_WORDS=256.
REQ-039 One sub-module, byte_pack16, SHALL hold the HI/LO byte assembly register.
REQ-040 The FSM and counters SHALL stay in prog_loader.

Verification
REQ-041 Basic load: load_start, then bytes 00 03 | 00 0A | 01 0F | 0C 00 → writes addr0=000A, addr1=010F, addr2=0C00; DONE, cpu_rst=0 after 11 cycles.
REQ-042 Length error: length 00 00 → ERR with err=1, cpu_rst=1, and no mem_we pulse.
REQ-043 Stall and restart:
  - rx_valid toggled low between bytes → no spurious writes, and the data matches REQ-041;
  - a later load_start from DONE → cpu_rst=1 again.
REQ-044 Full memory: N=256 with data=address → 256 writes, last at mem_addr=FF, then DONE.
REQ-045 Mid-load reset: rst asserted after 2 data words → IDLE the next cycle; a fresh load then succeeds from addr 0.
REQ-046 Checksum (macro defined): N=1, data 1234, checksum 1235 → DONE; checksum 1236 → ERR.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared constants and state encoding for the program loader (PROG_LOADER_CHECKSUM_EN adds CSUM states)
package prog_loader_pkg;

  localparam int RAM_ADDR_W     = 8;
  localparam int WORD_W         = 16;
  localparam int MAX_PROG_WORDS = 256;
  // One extra bit so a 256-word load reaches 256 without wrapping to 0.
  localparam int CNT_W          = RAM_ADDR_W + 1;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_DAT_HI  = 4'd3,
    ST_DAT_LO  = 4'd4,
    ST_WRITE   = 4'd5,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CSUM_HI = 4'd6,
    ST_CSUM_LO = 4'd7,
`endif
    ST_DONE    = 4'd8,
    ST_ERR     = 4'd9
  } state_e;

  // A program length is usable only when it names 1..MAX_PROG_WORDS words.
  function automatic logic len_ok(input logic [WORD_W-1:0] n);
    return (n != '0) && (n <= WORD_W'(MAX_PROG_WORDS));
  endfunction

endpackage

// File: rtl/prog_loader_byte_pack16.sv
// rtl/prog_loader_byte_pack16.sv - big-endian HI/LO byte assembly register for the program loader
module byte_pack16
  import prog_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic [WORD_W-1:0] peek_o
);

  logic [7:0] hi_q;
  logic [7:0] lo_q;

  // Capture the high byte first, then the low byte, into the word register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we_i) hi_q <= byte_i;
      if (lo_we_i) lo_q <= byte_i;
    end
  end

  assign word_o = {hi_q, lo_q};
  // Word as it will look once the byte currently on the link is latched as LO;
  // lets the FSM judge a length or checksum in the same cycle it arrives.
  assign peek_o = {hi_q, byte_i};

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial program loader FSM writing words into program RAM (optional PROG_LOADER_CHECKSUM_EN)
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [RAM_ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  output logic                  mem_we,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] acc_q, acc_d;
`endif
  logic              hi_we;
  logic              lo_we;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] peek;

  byte_pack16 u_pack (
    .clk_i   (clk),
    .rst_i   (rst),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .byte_i  (rx_data),
    .word_o  (word),
    .peek_o  (peek)
  );

  // State, word counter, length and checksum registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  // Next-state decode plus the byte-accept and write strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    acc_d    = acc_q;
`endif
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    rx_ready = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (load_start) begin
          state_d = ST_LEN_HI;
          cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      ST_LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          hi_we   = 1'b1;
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          lo_we = 1'b1;
          if (len_ok(peek)) begin
            len_d   = peek[CNT_W-1:0];
`ifdef PROG_LOADER_CHECKSUM_EN
            acc_d   = acc_q + peek;
`endif
            state_d = ST_DAT_HI;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_DAT_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          hi_we   = 1'b1;
          state_d = ST_DAT_LO;
        end
      end
      ST_DAT_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          lo_we   = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
        acc_d  = acc_q + word;
`endif
        if ((cnt_q + CNT_W'(1)) == len_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = ST_CSUM_HI;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_DAT_HI;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          hi_we   = 1'b1;
          state_d = ST_CSUM_LO;
        end
      end
      ST_CSUM_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          lo_we   = 1'b1;
          state_d = (peek == acc_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr  = cnt_q[RAM_ADDR_W-1:0];
  assign mem_wdata = word;
  assign cpu_rst   = (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader (honours PROG_LOADER_CHECKSUM_EN)
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, load_start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, mem_we, cpu_rst, done, err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] stim_len, stim_csum;
  logic [15:0] stim_words[$];
  int          gap_max;
  bit          pulse_mid;

  bit          obs_timeout;
  int          obs_lat;
  logic [2:0]  obs_flags;
  logic [23:0] wr_q[$];

  logic [2:0]  exp_flags;
  int          exp_lat;
  logic [23:0] exp_wr[$];

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Free-running cycle count for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every RAM write strobe seen mid-cycle.
  always @(negedge clk) if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});

  function automatic logic [15:0] calc_csum();
    logic [15:0] s = stim_len;
    foreach (stim_words[i]) s = s + stim_words[i];
    return s;
  endfunction

  // Expected outcome from the load rules: {done, err, cpu_rst}, writes, latency.
  function automatic void build_expect();
    exp_wr.delete();
    if (stim_len == 16'd0 || stim_len > 16'd256) begin
      exp_flags = 3'b011;
      exp_lat   = 2;
      return;
    end
    for (int i = 0; i < int'(stim_len); i++) exp_wr.push_back({8'(i), stim_words[i]});
    exp_lat = 2 + 3 * int'(stim_len) + (CSUM_EN ? 2 : 0);
    if (CSUM_EN && stim_csum != calc_csum()) exp_flags = 3'b011;
    else exp_flags = 3'b100;
  endfunction

  function automatic int count_wr_diff();
    int n = 0;
    foreach (exp_wr[i]) if (i >= wr_q.size() || wr_q[i] !== exp_wr[i]) n++;
    return n;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (gap) begin rx_valid = 1'b0; @(negedge clk); end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 100; t++) begin
      if (rx_ready === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    obs_timeout = 1'b1;
    rx_valid = 1'b0;
  endtask

  task automatic run_load();
    int start;
    wr_q.delete();
    obs_timeout = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    start = cyc;
    send_byte(stim_len[15:8]);
    send_byte(stim_len[7:0]);
    if (stim_len != 16'd0 && stim_len <= 16'd256) begin
      if (pulse_mid) begin load_start = 1'b1; @(negedge clk); load_start = 1'b0; end
      foreach (stim_words[i]) begin
        send_byte(stim_words[i][15:8]);
        send_byte(stim_words[i][7:0]);
      end
      if (CSUM_EN) begin
        send_byte(stim_csum[15:8]);
        send_byte(stim_csum[7:0]);
      end
    end
    for (int t = 0; t < 40; t++) begin
      if (done === 1'b1 || err === 1'b1) break;
      @(negedge clk);
    end
    obs_lat   = cyc - start;
    obs_flags = {done, err, cpu_rst};
    if (done !== 1'b1 && err !== 1'b1) obs_timeout = 1'b1;
    @(negedge clk);
    if (obs_timeout) begin rst = 1'b1; @(negedge clk); rst = 1'b0; end
  endtask

  task automatic make_random(input int n);
    stim_len = 16'(n);
    stim_words.delete();
    for (int i = 0; i < n; i++) stim_words.push_back(16'($urandom));
    stim_csum = calc_csum();
  endtask

  task automatic test_reset();
    rst = 1'b1; load_start = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
    repeat (3) @(negedge clk);
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if ({done, err, cpu_rst} !== 3'b001) begin failures++; $display("FAIL reset_flags got=%b exp=001", {done, err, cpu_rst}); end
    checks++; if (mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin failures++; $display("FAIL reset_mem_bus got=%h/%h exp=00/0000", mem_addr, mem_wdata); end
    rst = 1'b0; load_start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL idle_hold_rx_ready got=%b exp=0", rx_ready); end
    rx_valid = 1'b0;
  endtask

  task automatic test_basic();
    stim_len = 16'd3;
    stim_words = '{16'h000A, 16'h010F, 16'h0C00};
    stim_csum = calc_csum();
    gap_max = 0; pulse_mid = 1'b0;
    build_expect();
    run_load();
    checks++; if (obs_timeout || obs_flags !== exp_flags) begin failures++; $display("FAIL basic_flags got=%b to=%0d exp=%b", obs_flags, obs_timeout, exp_flags); end
    checks++; if (obs_lat !== exp_lat) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", obs_lat, exp_lat); end
    checks++; if (wr_q.size() !== exp_wr.size()) begin failures++; $display("FAIL basic_wr_count got=%0d exp=%0d", wr_q.size(), exp_wr.size()); end
    checks++; if (count_wr_diff() !== 0) begin failures++; $display("FAIL basic_wr_data bad=%0d exp=0", count_wr_diff()); end
  endtask

  task automatic test_len_error();
    for (int k = 0; k < 2; k++) begin
      stim_len = (k == 0) ? 16'd0 : 16'($urandom_range(257, 65535));
      stim_words.delete();
      gap_max = k; pulse_mid = 1'b0;
      build_expect();
      run_load();
      checks++; if (obs_timeout || obs_flags !== exp_flags) begin failures++; $display("FAIL len_err_flags len=%h got=%b exp=%b", stim_len, obs_flags, exp_flags); end
      checks++; if (wr_q.size() !== 0) begin failures++; $display("FAIL len_err_no_write len=%h got=%0d exp=0", stim_len, wr_q.size()); end
    end
    checks++; if (obs_lat > 2 + 2 * gap_max + 2 || rx_ready !== 1'b0) begin failures++; $display("FAIL len_err_hold lat=%0d ready=%b exp_ready=0", obs_lat, rx_ready); end
  endtask

  task automatic test_stall_restart();
    stim_len = 16'd3;
    stim_words = '{16'h000A, 16'h010F, 16'h0C00};
    stim_csum = calc_csum();
    gap_max = 3; pulse_mid = 1'b0;
    build_expect();
    run_load();
    checks++; if (obs_timeout || obs_flags !== exp_flags) begin failures++; $display("FAIL stall_flags got=%b exp=%b", obs_flags, exp_flags); end
    checks++; if (wr_q.size() !== exp_wr.size() || count_wr_diff() !== 0) begin failures++; $display("FAIL stall_writes got=%0d bad=%0d exp=%0d", wr_q.size(), count_wr_diff(), exp_wr.size()); end
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    checks++; if ({done, err, cpu_rst, rx_ready} !== 4'b0011) begin failures++; $display("FAIL restart_flags got=%b exp=0011", {done, err, cpu_rst, rx_ready}); end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_ignore_start();
    make_random(int'($urandom_range(2, 6)));
    gap_max = 0; pulse_mid = 1'b1;
    build_expect();
    run_load();
    pulse_mid = 1'b0;
    checks++; if (obs_timeout || obs_flags !== exp_flags) begin failures++; $display("FAIL ignore_start_flags got=%b exp=%b", obs_flags, exp_flags); end
    checks++; if (obs_lat !== exp_lat + 1) begin failures++; $display("FAIL ignore_start_latency got=%0d exp=%0d", obs_lat, exp_lat + 1); end
    checks++; if (count_wr_diff() !== 0 || wr_q.size() !== exp_wr.size()) begin failures++; $display("FAIL ignore_start_writes bad=%0d got=%0d exp=%0d", count_wr_diff(), wr_q.size(), exp_wr.size()); end
  endtask

  task automatic test_full();
    stim_len = 16'd256;
    stim_words.delete();
    for (int i = 0; i < 256; i++) stim_words.push_back(16'(i));
    stim_csum = calc_csum();
    gap_max = 0; pulse_mid = 1'b0;
    build_expect();
    run_load();
    checks++; if (obs_timeout || obs_flags !== exp_flags) begin failures++; $display("FAIL full_flags got=%b exp=%b", obs_flags, exp_flags); end
    checks++; if (wr_q.size() !== 256) begin failures++; $display("FAIL full_wr_count got=%0d exp=256", wr_q.size()); end
    checks++; if (wr_q.size() == 256 && wr_q[255][23:16] !== 8'hFF) begin failures++; $display("FAIL full_last_addr got=%h exp=ff", wr_q[255][23:16]); end
    checks++; if (count_wr_diff() !== 0) begin failures++; $display("FAIL full_wr_data bad=%0d exp=0", count_wr_diff()); end
    checks++; if (obs_lat !== exp_lat) begin failures++; $display("FAIL full_latency got=%0d exp=%0d", obs_lat, exp_lat); end
  endtask

  task automatic test_mid_reset();
    wr_q.delete();
    obs_timeout = 1'b0;
    gap_max = 0;
    make_random(4);
    load_start = 1'b1; @(negedge clk); load_start = 1'b0;
    send_byte(8'h00); send_byte(8'h04);
    for (int i = 0; i < 2; i++) begin
      send_byte(stim_words[i][15:8]);
      send_byte(stim_words[i][7:0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({rx_ready, mem_we, done, err, cpu_rst} !== 5'b00001) begin failures++; $display("FAIL midrst_ctrl got=%b exp=00001", {rx_ready, mem_we, done, err, cpu_rst}); end
    checks++; if (mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin failures++; $display("FAIL midrst_bus got=%h/%h exp=00/0000", mem_addr, mem_wdata); end
    checks++; if (obs_timeout || wr_q.size() !== 2) begin failures++; $display("FAIL midrst_partial_writes got=%0d exp=2", wr_q.size()); end
    make_random(int'($urandom_range(1, 5)));
    build_expect();
    run_load();
    checks++; if (obs_timeout || obs_flags !== exp_flags || count_wr_diff() !== 0) begin failures++; $display("FAIL midrst_reload flags=%b exp=%b bad=%0d", obs_flags, exp_flags, count_wr_diff()); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      make_random(int'($urandom_range(1, 24)));
      if (CSUM_EN && $urandom_range(0, 2) == 0) stim_csum = stim_csum ^ 16'($urandom_range(1, 65535));
      gap_max = int'($urandom_range(0, 2)); pulse_mid = 1'b0;
      build_expect();
      run_load();
      checks++; if (obs_timeout || obs_flags !== exp_flags) begin failures++; $display("FAIL random%0d_flags got=%b exp=%b", k, obs_flags, exp_flags); end
      checks++; if (wr_q.size() !== exp_wr.size() || count_wr_diff() !== 0) begin failures++; $display("FAIL random%0d_writes got=%0d bad=%0d exp=%0d", k, wr_q.size(), count_wr_diff(), exp_wr.size()); end
      if (gap_max == 0) begin
        checks++; if (obs_lat !== exp_lat) begin failures++; $display("FAIL random%0d_latency got=%0d exp=%0d", k, obs_lat, exp_lat); end
      end
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int k = 0; k < 2; k++) begin
      stim_len = 16'd1;
      stim_words = '{16'h1234};
      stim_csum = (k == 0) ? 16'h1235 : 16'h1236;
      gap_max = 0; pulse_mid = 1'b0;
      run_load();
      checks++; if (obs_timeout || obs_flags !== ((k == 0) ? 3'b100 : 3'b011)) begin failures++; $display("FAIL csum%0d_flags got=%b exp=%b", k, obs_flags, (k == 0) ? 3'b100 : 3'b011); end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    gap_max = 0; pulse_mid = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_len_error();
    test_stall_restart();
    test_ignore_start();
    test_full();
    test_mid_reset();
    test_random();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
